sbox_rom_arbiter: RTL and testbench

Shares the single external S-Box ROM between several AES engines: key expansion, the encipher block and the decipher block. Each requester issues one byte-read at a time through a req/ack handshake. The arbiter grants requesters round-robin, drives the physical ROM pins with programmable wait states, and returns the captured byte with a one-cycle ack. It sits between the `aes_sbox` instances and the board-level ROM pins `rom_addr`, `rom_data`, `rom_ce_n` and `rom_oe_n`.

---
 rtl/sbox_rom_arbiter_if.sv | 21 ++
 rtl/sbox_rom_arbiter.sv | 139 +++++++++++++
 tb/tb_sbox_rom_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sbox_rom_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sbox_rom_arbiter_if : requester-side bus of the shared S-Box ROM arbiter
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
interface sbox_rom_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_addr;
  logic [NREQ-1:0]   ack;
  logic [7:0]        rdata;
  logic              busy;
  logic [2:0]        grant_id;

  modport master (output req, output req_addr,
                  input  ack, input rdata, input busy, input grant_id);
  modport slave  (input  req, input req_addr,
                  output ack, output rdata, output busy, output grant_id);
endinterface
`default_nettype wire

// File: rtl/sbox_rom_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sbox_rom_arbiter : round-robin arbiter sharing one external S-Box ROM
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module sbox_rom_arbiter #(
  parameter int NREQ        = 3,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  sbox_rom_arbiter_if.slave bus,
  output logic [7:0]       o_rom_addr,
  input  wire logic [7:0]  i_rom_data,
  output logic             o_rom_ce_n,
  output logic             o_rom_oe_n
);

  generate
    if (WAIT_CYCLES < 1 || NREQ < 2 || NREQ > 8) begin : g_param_check
      $error("sbox_rom_arbiter: NREQ must be 2..8 and WAIT_CYCLES >= 1");
    end
  endgenerate

  localparam int             CW         = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]  C_CNT_LOAD = CW'(WAIT_CYCLES - 1);
  localparam logic [3:0]     C_NREQ     = 4'(NREQ);
  localparam logic [2:0]     C_LAST     = 3'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_ptr;
  logic [2:0]      r_grant;
  logic [7:0]      r_addr;
  logic            r_ce_n;
  logic            r_oe_n;
  logic [NREQ-1:0] r_ack;
  logic [7:0]      r_rdata;
  logic [CW-1:0]   r_cnt;

  logic [NREQ-1:0] w_req_rot;
  logic [2:0]      w_off;
  logic [3:0]      w_sum;
  logic [2:0]      w_winner;
  logic [7:0]      w_win_addr;
  logic [NREQ-1:0] w_ack_oh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (|bus.req) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_STROBE;
      S_STROBE: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Rotate requests so the pointer lands on bit 0; lowest set bit is the winner.
  always_comb begin
    w_req_rot  = NREQ'({bus.req, bus.req} >> r_ptr);
    w_off      = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_req_rot[j]) w_off = 3'(j);
    end
    w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
    w_winner   = (w_sum >= C_NREQ) ? 3'(w_sum - C_NREQ) : w_sum[2:0];
    w_win_addr = '0;
    w_ack_oh   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_winner == 3'(j)) w_win_addr = bus.req_addr[8*j +: 8];
      w_ack_oh[j] = (r_grant == 3'(j));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_addr  <= '0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_ack   <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_grant <= w_winner;
            r_addr  <= w_win_addr;
            r_ce_n  <= 1'b0;
          end
        end
        S_SETUP: begin
          r_cnt  <= C_CNT_LOAD;
          r_oe_n <= 1'b0;
        end
        S_STROBE: begin
          if (r_cnt == '0) begin
            r_rdata <= i_rom_data;
            r_ack   <= w_ack_oh;
            r_oe_n  <= 1'b1;
            r_ce_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_ack <= '0;
          r_ptr <= (r_grant == C_LAST) ? 3'd0 : r_grant + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ack      = r_ack;
  assign bus.rdata    = r_rdata;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.grant_id = r_grant;
  assign o_rom_addr   = r_addr;
  assign o_rom_ce_n   = r_ce_n;
  assign o_rom_oe_n   = r_oe_n;

endmodule
`default_nettype wire

// File: tb/tb_sbox_rom_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sbox_rom_arbiter : scoreboard bench for the shared S-Box ROM arbiter
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_sbox_rom_arbiter;
  localparam int NREQ = 3;
  localparam int W    = 2;
  localparam int W4   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  sbox_rom_arbiter_if #(.NREQ(NREQ)) bus ();
  sbox_rom_arbiter_if #(.NREQ(NREQ)) bus4 ();
  logic [7:0] rom_addr, rom_data, rom_addr4, rom_data4;
  logic       ce_n, oe_n, ce4_n, oe4_n;

  sbox_rom_arbiter #(.NREQ(NREQ), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_rom_ce_n(ce_n), .o_rom_oe_n(oe_n));

  sbox_rom_arbiter #(.NREQ(NREQ), .WAIT_CYCLES(W4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4),
    .o_rom_addr(rom_addr4), .i_rom_data(rom_data4), .o_rom_ce_n(ce4_n), .o_rom_oe_n(oe4_n));

  logic [7:0] inv_sbox [0:255] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

  // ROM bus model: data is X until rom_oe_n has been low for the full wait time.
  int oe_cnt = 0, oe4_cnt = 0;
  initial forever begin
    @(negedge clk);
    oe_cnt  = oe_n  ? 0 : oe_cnt + 1;
    oe4_cnt = oe4_n ? 0 : oe4_cnt + 1;
  end
  assign rom_data  = (!oe_n  && !ce_n  && oe_cnt  >= W)  ? inv_sbox[rom_addr]  : 8'hxx;
  assign rom_data4 = (!oe4_n && !ce4_n && oe4_cnt >= W4) ? inv_sbox[rom_addr4] : 8'hxx;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one access per W+3 cycles, rotating priority from the last grantee + 1.
  typedef struct { int id; logic [7:0] data; int due; } exp_t;
  exp_t       sb_q [$];
  int         cyc = 0;
  int         free_at = 0, mptr = 0, win_e = -1000, exp_gid = 0;
  logic [7:0] exp_addr = 8'h00;

  initial begin
    exp_t e;
    int   g, idx;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        sb_q.delete();
        free_at = 0; mptr = 0; win_e = -1000;
      end else if (cyc >= free_at && bus.req != '0) begin
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          idx = (mptr + k) % NREQ;
          if (g < 0 && bus.req[idx]) g = idx;
        end
        exp_addr = bus.req_addr[8*g +: 8];
        exp_gid  = g;
        e.id = g; e.data = inv_sbox[exp_addr]; e.due = cyc + W + 2;
        sb_q.push_back(e);
        win_e   = cyc;
        free_at = cyc + W + 3;
        mptr    = (g + 1) % NREQ;
      end
      cyc++;
    end
  end

  // Monitor: compares pins every cycle and pops the scoreboard on each ack.
  initial begin
    exp_t            e;
    int              c;
    bit              e_busy, e_ce, e_oe;
    logic [NREQ-1:0] oh;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        c      = cyc;
        e_busy = (c >= win_e + 1) && (c <= win_e + W + 2);
        e_ce   = (c >= win_e + 1) && (c <= win_e + W + 1);
        e_oe   = (c >= win_e + 2) && (c <= win_e + W + 1);
        chk("busy", bus.busy, e_busy);
        chk("rom_ce_n", ce_n, !e_ce);
        chk("rom_oe_n", oe_n, !e_oe);
        if (e_busy) begin
          chk("rom_addr", rom_addr, exp_addr);
          chk("grant_id", bus.grant_id, exp_gid);
        end
        if (bus.ack != '0) begin
          if (sb_q.size() == 0) chk("unexpected_ack", bus.ack, 0);
          else begin
            e  = sb_q.pop_front();
            oh = '0; oh[e.id] = 1'b1;
            chk("ack_onehot", bus.ack, oh);
            chk("rdata", bus.rdata, e.data);
            chk("ack_cycle", c, e.due);
          end
        end else if (sb_q.size() > 0 && sb_q[0].due < c) begin
          e = sb_q.pop_front();
          chk("missing_ack", bus.ack[e.id], 1);
        end
      end
    end
  end

  task automatic wait_ack(input int i, output bit ok, output int at);
    ok = 0; at = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (bus.ack[i]) begin ok = 1; at = cyc; end
    end
    chk("ack_seen", ok, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      done = (sb_q.size() == 0) && !bus.busy;
    end
    chk("idle_reached", done, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic dut4_read(input logic [7:0] a);
    int noe = 0, nce = 0;
    bit ok = 0;
    @(negedge clk);
    bus4.req[0] = 1'b1; bus4.req_addr[7:0] = a;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      if (!oe4_n) noe++;
      if (!ce4_n) nce++;
      if (bus4.ack[0]) begin
        ok = 1;
        chk("w4_rdata", bus4.rdata, inv_sbox[a]);
        bus4.req[0] = 1'b0;
      end
    end
    chk("w4_ack_seen", ok, 1);
    chk("w4_oe_cycles", noe, W4);
    chk("w4_ce_cycles", nce, W4 + 1);
    @(negedge clk);
  endtask

  initial begin
    bit         ok;
    int         at, prev, id, n0, n1, seen2;
    logic [7:0] sim_exp [3];
    sim_exp[0] = 8'h52; sim_exp[1] = 8'h09; sim_exp[2] = 8'h6a;

    reset_n = 1'b0;
    bus.req = '0;  bus.req_addr = '0;
    bus4.req = '0; bus4.req_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_ce_n", ce_n, 1);
    chk("rst_oe_n", oe_n, 1);
    @(posedge clk); #1 reset_n = 1'b1;

    // single read by requester 1
    @(negedge clk);
    bus.req[1] = 1'b1; bus.req_addr[15:8] = 8'h53;
    wait_ack(1, ok, at);
    chk("single_ack", bus.ack, 3'b010);
    chk("single_rdata", bus.rdata, 8'h50);
    bus.req[1] = 1'b0;
    @(negedge clk);
    chk("single_busy_after", bus.busy, 0);
    wait_idle();

    // all three requesting continuously from a reset pointer
    do_reset();
    @(negedge clk);
    bus.req = 3'b111; bus.req_addr = {8'h02, 8'h01, 8'h00};
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      ok = 0; id = -1;
      for (int n = 0; n < 20 && !ok; n++) begin
        @(negedge clk);
        if (bus.ack != '0) begin
          ok = 1; at = cyc;
          for (int i = 0; i < NREQ; i++) if (bus.ack[i]) id = i;
        end
      end
      chk("sim_ack_seen", ok, 1);
      chk("sim_order", id, k % 3);
      chk("sim_rdata", bus.rdata, sim_exp[k % 3]);
      if (k > 0) chk("sim_spacing", at - prev, W + 3);
      prev = at;
    end
    bus.req = '0;
    wait_idle();

    // fairness: req[0] held, req[2] arrives once
    @(negedge clk);
    bus.req[0] = 1'b1; bus.req_addr[7:0] = 8'h10;
    repeat (2) @(negedge clk);
    bus.req[2] = 1'b1; bus.req_addr[23:16] = 8'h20;
    n0 = 0; n1 = 0; seen2 = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.ack[0] && !seen2) n0++;
      if (bus.ack[1]) n1++;
      if (bus.ack[2]) begin seen2 = 1; bus.req[2] = 1'b0; end
    end
    chk("fair_req2_served", seen2, 1);
    chk("fair_wait_bound", (n0 <= 1), 1);
    chk("fair_no_ack1", n1, 0);
    bus.req[0] = 1'b0;
    wait_idle();

    // asynchronous reset during the second strobe cycle
    @(negedge clk);
    bus.req[1] = 1'b1; bus.req_addr[15:8] = 8'h40;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    bus.req[1] = 1'b0;
    #1;
    chk("rst_mid_ce_n", ce_n, 1);
    chk("rst_mid_oe_n", oe_n, 1);
    chk("rst_mid_ack", bus.ack, 0);
    chk("rst_mid_rdata", bus.rdata, 0);
    chk("rst_mid_busy", bus.busy, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    bus.req[2] = 1'b1; bus.req_addr[23:16] = 8'h7f;
    wait_ack(2, ok, at);
    chk("post_rst_rdata", bus.rdata, inv_sbox[8'h7f]);
    bus.req[2] = 1'b0;
    wait_idle();

    // early request drop and address change during SETUP
    @(negedge clk);
    bus.req[0] = 1'b1; bus.req_addr[7:0] = 8'h33;
    @(posedge clk);
    @(negedge clk);
    bus.req[0] = 1'b0; bus.req_addr[7:0] = 8'hcc;
    wait_ack(0, ok, at);
    chk("drop_rdata", bus.rdata, inv_sbox[8'h33]);
    wait_idle();

    // randomized traffic; each requester holds req until its ack
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ack[i]) begin
          if ($urandom_range(1, 0) == 1) bus.req_addr[8*i +: 8] = 8'($urandom);
          else bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(3, 0) == 0) begin
          bus.req[i] = 1'b1;
          bus.req_addr[8*i +: 8] = 8'($urandom);
        end
      end
    end
    bus.req = '0;
    wait_idle();

    // longer wait-state build with an X-driving bus
    dut4_read(8'h53);
    dut4_read(8'h00);
    dut4_read(8'hfe);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
